mem_port_arbiter: RTL and testbench

- Shares one multi-cycle external memory port between the fetch-stage requester (instruction read) and the MEM-stage requester (data load/store) of the 5-stage pipeline.
- Uses a registered request/acknowledge handshake toward memory.
- Returns a one-cycle ready pulse with read data to the granted requester.
- Drives a pipeline-wide stall while any request is outstanding.

---
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one multi-cycle external memory port between the instruction-fetch
// requester and the MEM-stage data requester. Exactly one access is in
// flight at a time: IDLE picks a winner and registers the request, BUSY
// waits for the single-cycle acknowledge (or gives up after TIMEOUT_CYC
// cycles), and RESP returns a one-cycle ready pulse to the winner.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // fetch requester (read only)
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,
    // data requester (load/store)
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ready_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    // external memory port
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // pipeline status
    output logic              stall_o,
    output logic              err_o
);

    // Counter widths sized to hold their terminal values.
    localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    // Starvation threshold and the last BUSY count before the access is abandoned.
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Decisions produced by the next-state logic for the datapath registers.
    logic              grant;       // a winner is picked this cycle
    logic              grant_data;  // the winner is the data requester
    logic              finish;      // the in-flight access ends this cycle
    logic              abort;       // it ends because the memory never answered

    // Registered context of the in-flight access.
    logic              win_data;
    logic [SC_W-1:0]   starve_cnt;
    logic [TC_W-1:0]   tmo_cnt;

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and arbitration decisions.
    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_data = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (if_req_i || dm_req_i) begin
                    grant = 1'b1;
                    // Data normally wins a tie; fetch wins once it has been
                    // passed over STARVE_LIMIT times in a row.
                    grant_data = dm_req_i && (!if_req_i || (starve_cnt != SC_MAX));
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                // An ack arriving on the timeout cycle still counts as success.
                if (mem_ack_i) begin
                    finish    = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_cnt == TC_LAST) begin
                    finish    = 1'b1;
                    abort     = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // Inputs seen here belong to the next arbitration round.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory port registers: loaded at grant, held through BUSY.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else if (grant) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= grant_data & dm_we_i;
            mem_addr_o  <= grant_data ? dm_addr_i : if_addr_i;
            mem_wdata_o <= grant_data ? dm_wdata_i : '0;
        end else if (finish) begin
            mem_req_o   <= 1'b0;
        end
    end

    // Remember which requester owns the in-flight access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_data <= 1'b0;
        end else if (grant) begin
            win_data <= grant_data;
        end
    end

    // Count data grants taken while fetch was also waiting; a fetch grant resets it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (!grant_data) begin
                starve_cnt <= '0;
            end else if (if_req_i && (starve_cnt != SC_MAX)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

    // Count BUSY cycles without an acknowledge; restarts with every grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (grant) begin
            tmo_cnt <= '0;
        end else if ((state == BUSY) && !finish) begin
            tmo_cnt <= tmo_cnt + TC_W'(1);
        end
    end

    // One-cycle ready pulse to the winner, coinciding with RESP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_ready_o <= 1'b0;
            dm_ready_o <= 1'b0;
        end else begin
            if_ready_o <= finish & ~win_data;
            dm_ready_o <= finish & win_data;
        end
    end

    // Return read data to the winner; an abandoned access returns zero and a
    // completed store leaves the load data untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_rdata_o <= '0;
            dm_rdata_o <= '0;
        end else if (finish) begin
            if (win_data) begin
                if (abort) begin
                    dm_rdata_o <= '0;
                end else if (!mem_we_o) begin
                    dm_rdata_o <= mem_rdata_i;
                end
            end else begin
                if_rdata_o <= abort ? '0 : mem_rdata_i;
            end
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (abort) begin
            err_o <= 1'b1;
        end
    end

    // A requester stalls the pipeline until the cycle its ready pulse arrives.
    assign stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter
// Drives fetch/data requesters and a memory responder, and compares the
// arbiter against a transaction-level model that tracks each access by the
// clock edge it was granted on and the edge it completed on.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT_CYC  = 255;
    localparam int NEVER        = 100000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ready_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic              dm_ready_o;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              stall_o;
    logic              err_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ready_o(dm_ready_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .stall_o(stall_o), .err_o(err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pending transactions for each requester.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xact_t;

    logic [ADDR_W-1:0] if_q[$];
    xact_t             dm_q[$];

    // Stimulus knobs.
    bit                gap_rand    = 1'b0;
    bit                spur_en     = 1'b0;
    bit                rdata_fix_en = 1'b0;
    logic [DATA_W-1:0] rdata_fix   = '0;
    int                lat_fixed   = 0;     // 0 = random latency 1..4
    bit                force_ack   = 1'b0;

    // Memory responder state.
    bit resp_active   = 1'b0;
    int resp_cnt      = 0;
    bit prev_mem_req  = 1'b0;

    // Observations.
    int edge_n   = 0;
    int req_run  = 0;
    int last_run = 0;
    bit glog[$];

    // Reference model.
    bit                m_busy    = 1'b0;
    int                m_grant_e = 0;
    bit                m_win_d   = 1'b0;
    bit                m_we      = 1'b0;
    int                m_free_e  = 0;
    int                m_starve  = 0;
    bit                m_err     = 1'b0;
    logic [DATA_W-1:0] m_if_rdata = '0;
    logic [DATA_W-1:0] m_dm_rdata = '0;
    bit                e_mem_req = 1'b0;
    bit                e_mem_we  = 1'b0;
    logic [ADDR_W-1:0] e_mem_addr = '0;
    logic [DATA_W-1:0] e_mem_wdata = '0;
    bit                e_if_ready = 1'b0;
    bit                e_dm_ready = 1'b0;

    // Advance the model by one edge using the inputs sampled at that edge.
    task automatic model_step();
        logic [DATA_W-1:0] val;
        bit tmo;
        e_if_ready = 1'b0;
        e_dm_ready = 1'b0;
        if (rst) begin
            m_busy = 0; m_starve = 0; m_err = 0;
            m_if_rdata = '0; m_dm_rdata = '0;
            e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
            m_free_e = edge_n + 1;
        end else if (m_busy) begin
            tmo = !mem_ack && (edge_n - m_grant_e == TIMEOUT_CYC);
            if (mem_ack || tmo) begin
                val = tmo ? '0 : mem_rdata;
                if (m_win_d) begin
                    if (tmo || !m_we) m_dm_rdata = val;
                    e_dm_ready = 1'b1;
                end else begin
                    m_if_rdata = val;
                    e_if_ready = 1'b1;
                end
                if (tmo) m_err = 1'b1;
                e_mem_req = 1'b0;
                m_busy    = 1'b0;
                m_free_e  = edge_n + 2;
            end
        end else if (edge_n >= m_free_e && (if_req || dm_req)) begin
            m_win_d = dm_req && (!if_req || m_starve != STARVE_LIMIT);
            if (!m_win_d) m_starve = 0;
            else if (if_req) m_starve++;
            m_we        = m_win_d && dm_we;
            e_mem_req   = 1'b1;
            e_mem_we    = m_we;
            e_mem_addr  = m_win_d ? dm_addr : if_addr;
            e_mem_wdata = dm_wdata;
            m_busy      = 1'b1;
            m_grant_e   = edge_n;
        end
    endtask

    // Compare registered outputs after the edge with the model.
    task automatic check_outputs();
        check_eq("mem_req", mem_req_o, e_mem_req);
        if (e_mem_req) begin
            check_eq("mem_addr", mem_addr_o, e_mem_addr);
            check_eq("mem_we", mem_we_o, e_mem_we);
            if (e_mem_we) check_eq("mem_wdata", mem_wdata_o, e_mem_wdata);
        end
        check_eq("if_ready", if_ready_o, e_if_ready);
        check_eq("dm_ready", dm_ready_o, e_dm_ready);
        check_eq("if_rdata", if_rdata_o, m_if_rdata);
        check_eq("dm_rdata", dm_rdata_o, m_dm_rdata);
        check_eq("err", err_o, m_err);
        check_eq("starve_cnt", dut.starve_cnt, m_starve);
        if (mem_req_o) req_run++;
        else if (req_run != 0) begin
            last_run = req_run;
            req_run  = 0;
        end
        if (mem_req_o && !prev_mem_req) glog.push_back(mem_addr_o[ADDR_W-1]);
    endtask

    // Drive requesters and the memory responder for the next edge.
    task automatic drive_next();
        xact_t x;
        mem_ack   = 1'b0;
        mem_rdata = $urandom();
        if (mem_req_o && !prev_mem_req) begin
            resp_active = 1'b1;
            resp_cnt = (lat_fixed == 0) ? int'($urandom_range(1, 4)) : lat_fixed;
        end
        if (resp_active && !mem_req_o) resp_active = 1'b0;
        if (force_ack) begin
            mem_ack   = 1'b1;
            force_ack = 1'b0;
        end else if (resp_active) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_ack     = 1'b1;
                mem_rdata   = rdata_fix_en ? rdata_fix : $urandom();
                resp_active = 1'b0;
            end
        end else if (spur_en && !mem_req_o && $urandom_range(0, 7) == 0) begin
            mem_ack = 1'b1;
        end
        prev_mem_req = mem_req_o;

        if (if_req && if_ready_o) if_req = 1'b0;
        if (!if_req) begin
            if_addr = $urandom();
            if (if_q.size() != 0 && (!gap_rand || $urandom_range(0, 2) == 0)) begin
                if_req  = 1'b1;
                if_addr = if_q.pop_front();
            end
        end
        if (dm_req && dm_ready_o) dm_req = 1'b0;
        if (!dm_req) begin
            dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom(); dm_wdata = $urandom();
            if (dm_q.size() != 0 && (!gap_rand || $urandom_range(0, 2) == 0)) begin
                x = dm_q.pop_front();
                dm_req = 1'b1; dm_we = x.we; dm_addr = x.addr; dm_wdata = x.wdata;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        model_step();
        check_outputs();
        drive_next();
        #1;
        check_eq("stall", stall_o, (if_req & ~e_if_ready) | (dm_req & ~e_dm_ready));
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((if_q.size() != 0 || dm_q.size() != 0 || if_req || dm_req || m_busy) && n < budget) begin
            tick();
            n++;
        end
        check_eq("idle_reached", (n < budget), 1);
        repeat (3) tick();
    endtask

    task automatic reset_outputs_check(input string tag);
        check_eq({tag, "_mem_req"}, mem_req_o, 0);
        check_eq({tag, "_mem_we"}, mem_we_o, 0);
        check_eq({tag, "_mem_addr"}, mem_addr_o, 0);
        check_eq({tag, "_mem_wdata"}, mem_wdata_o, 0);
        check_eq({tag, "_if_ready"}, if_ready_o, 0);
        check_eq({tag, "_dm_ready"}, dm_ready_o, 0);
        check_eq({tag, "_if_rdata"}, if_rdata_o, 0);
        check_eq({tag, "_dm_rdata"}, dm_rdata_o, 0);
        check_eq({tag, "_err"}, err_o, 0);
    endtask

    initial begin
        bit exp_order[10];
        string pat;
        xact_t x;

        // Reset.
        rst = 1'b1;
        repeat (2) tick();
        reset_outputs_check("rst");
        rst = 1'b0;
        repeat (2) tick();

        // Fetch only, memory answers two cycles after the request.
        lat_fixed = 2; rdata_fix_en = 1'b1; rdata_fix = 32'h0050_0093;
        if_q.push_back(32'h0000_0010);
        run_until_idle(50);
        check_eq("fetch_rdata", if_rdata_o, 32'h0050_0093);
        check_eq("fetch_req_len", last_run, 2);

        // Store with immediate ack; load data must stay at its reset value.
        lat_fixed = 1; rdata_fix = 32'hDEAD_BEEF;
        x.we = 1'b1; x.addr = 32'h0000_0100; x.wdata = 32'hCAFE_F00D;
        dm_q.push_back(x);
        run_until_idle(50);
        check_eq("store_rdata_keep", dm_rdata_o, 32'h0);
        check_eq("store_req_len", last_run, 1);

        // Contention: both requesters held, fetch wins every fifth grant.
        rdata_fix_en = 1'b0;
        glog.delete();
        for (int i = 0; i < 10; i++) begin
            if_q.push_back(32'h0000_1000 + 32'(i * 4));
            x.we = 1'($urandom_range(0, 1)); x.addr = 32'h8000_0000 | 32'(i * 4); x.wdata = $urandom();
            dm_q.push_back(x);
        end
        run_until_idle(200);
        pat = "DDDDFDDDDF";
        for (int i = 0; i < 10; i++) exp_order[i] = (pat[i] == "D");
        check_eq("grant_count", (glog.size() >= 10), 1);
        for (int i = 0; i < 10 && i < glog.size(); i++)
            check_eq($sformatf("grant_order%0d", i), glog[i], exp_order[i]);

        // Ack arrives on the very cycle the timeout would fire.
        lat_fixed = TIMEOUT_CYC; rdata_fix_en = 1'b1; rdata_fix = 32'h1234_5678;
        x.we = 1'b0; x.addr = 32'h0000_0200; x.wdata = '0;
        dm_q.push_back(x);
        run_until_idle(400);
        check_eq("collide_err", err_o, 0);
        check_eq("collide_rdata", dm_rdata_o, 32'h1234_5678);
        check_eq("collide_req_len", last_run, TIMEOUT_CYC);

        // Timeout: the memory never answers a load.
        lat_fixed = NEVER;
        x.we = 1'b0; x.addr = 32'h0000_0300; x.wdata = '0;
        dm_q.push_back(x);
        run_until_idle(400);
        check_eq("tmo_err", err_o, 1);
        check_eq("tmo_rdata", dm_rdata_o, 0);
        check_eq("tmo_req_len", last_run, TIMEOUT_CYC);

        // Random traffic with gaps, random latency and stray acks.
        lat_fixed = 0; rdata_fix_en = 1'b0; gap_rand = 1'b1; spur_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if_q.push_back($urandom());
            x.we = 1'($urandom_range(0, 1)); x.addr = $urandom(); x.wdata = $urandom();
            dm_q.push_back(x);
        end
        run_until_idle(3000);
        check_eq("err_sticky", err_o, 1);
        gap_rand = 1'b0; spur_en = 1'b0;

        // Reset in the middle of an access, followed by a late ack.
        lat_fixed = NEVER;
        x.we = 1'b0; x.addr = 32'h0000_0400; x.wdata = '0;
        dm_q.push_back(x);
        repeat (6) tick();
        check_eq("pre_rst_req", mem_req_o, 1);
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
        if_q.delete(); dm_q.delete();
        force_ack = 1'b1;
        tick();
        check_eq("rst_edge_req", mem_req_o, 0);
        rst = 1'b0;
        tick();
        reset_outputs_check("midrst");
        repeat (3) tick();
        reset_outputs_check("midrst_late");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
